// File: rtl/device_rx.sv
// ---------------------------------------------------------------------------
// device_rx
//
// Remote-terminal receive-side handler for the MKIO (MIL-STD-1553) bus.
// A receive command word (start) announces N data words, with 0 meaning 32.
// Each data word from the decoder (rx_valid) is written into terminal memory.
// After the last word and the command-to-response pause, the status word
// {ADDRESS, error flag, 10'b0} is handed to the encoder with a two-cycle
// tx_ready request.
//
// A gap between data words longer than DW_TIMEOUT cycles aborts the message.
// No status word is sent in that case.
//
// Ports
//   clk        in   system clock, all state changes on posedge
//   reset      in   asynchronous active-low reset
//   start      in   one-cycle pulse, receive command word on rx_data
//   rx_data    in   16-bit decoded word (command on start, data on rx_valid)
//   rx_valid   in   one-cycle pulse, data word on rx_data
//   p_error    in   parity error for the word qualified by start/rx_valid
//   tx_data    out  16-bit word to encoder (status word)
//   tx_cd      out  encoder sync type: 0 = status/command, 1 = data
//   tx_ready   out  send request to encoder
//   tx_busy    in   encoder transmitting
//   mem_addr   out  5-bit memory write address
//   mem_data   out  16-bit memory write data
//   mem_we     out  one-cycle memory write strobe
//   busy       out  message in progress
//   words_rcvd out  data words stored in the last/current message (0..32)
//   done       out  one-cycle pulse, status word handed off
//   timeout    out  one-cycle pulse, message aborted on data-word gap
// ---------------------------------------------------------------------------
module device_rx #(
    parameter logic [4:0] ADDRESS      = 5'd1,
    parameter logic [7:0] PAUSE_CYCLES = 8'hFF,
    parameter logic [7:0] DW_TIMEOUT   = 8'd200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] rx_data,
    input  logic        rx_valid,
    input  logic        p_error,
    output logic [15:0] tx_data,
    output logic        tx_cd,
    output logic        tx_ready,
    input  logic        tx_busy,
    output logic [4:0]  mem_addr,
    output logic [15:0] mem_data,
    output logic        mem_we,
    output logic        busy,
    output logic [5:0]  words_rcvd,
    output logic        done,
    output logic        timeout
);

    typedef enum logic [2:0] {
        IDLE, INIT, WAIT_DW, PAUSE_WAIT, LOAD_SW, SEND_SW, END_WAIT
    } state_t;

    state_t      state, state_nxt;
    logic [5:0]  n_words;     // announced word count, 1..32
    logic [7:0]  gap_cnt;     // data-word gap counter, reused as pause counter
    logic        err_flag;
    logic [1:0]  rdy_cnt;     // tx_ready cycles issued in SEND_SW
    logic [5:0]  words_inc;
    logic        last_word;
    logic        gap_expire;

    assign words_inc = words_rcvd + 6'd1;

    // The timeout compare looks at the value the gap counter is about to
    // take. A word arriving in that same cycle is still accepted.
    always_comb begin
        last_word  = 1'b0;
        gap_expire = 1'b0;
        if (!start && state == WAIT_DW) begin
            last_word  = rx_valid && (words_inc == n_words);
            gap_expire = !rx_valid && (({1'b0, gap_cnt} + 9'd1) == {1'b0, DW_TIMEOUT});
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = INIT;
        end else begin
            case (state)
                IDLE:       state_nxt = IDLE;
                INIT:       state_nxt = WAIT_DW;
                WAIT_DW: begin
                    if (last_word)       state_nxt = PAUSE_WAIT;
                    else if (gap_expire) state_nxt = IDLE;
                end
                PAUSE_WAIT: if (gap_cnt == PAUSE_CYCLES) state_nxt = LOAD_SW;
                LOAD_SW:    state_nxt = SEND_SW;
                SEND_SW:    if (rdy_cnt == 2'd2) state_nxt = END_WAIT;
                END_WAIT:   if (!tx_busy) state_nxt = IDLE;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_words    <= 6'd0;
            gap_cnt    <= 8'd0;
            err_flag   <= 1'b0;
            rdy_cnt    <= 2'd0;
            tx_data    <= 16'd0;
            tx_cd      <= 1'b0;
            tx_ready   <= 1'b0;
            mem_addr   <= 5'd0;
            mem_data   <= 16'd0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
            words_rcvd <= 6'd0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            mem_we  <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
            if (start) begin
                // A restart drops any message in progress, including a
                // pending tx_ready request.
                n_words    <= (rx_data[4:0] == 5'd0) ? 6'd32 : {1'b0, rx_data[4:0]};
                words_rcvd <= 6'd0;
                gap_cnt    <= 8'd0;
                err_flag   <= p_error;
                rdy_cnt    <= 2'd0;
                tx_ready   <= 1'b0;
                busy       <= 1'b1;
            end else begin
                case (state)
                    WAIT_DW: begin
                        if (rx_valid) begin
                            // Words with a parity error are still stored.
                            // Only the status word reports the error.
                            mem_data   <= rx_data;
                            mem_addr   <= words_rcvd[4:0];
                            mem_we     <= 1'b1;
                            words_rcvd <= words_inc;
                            gap_cnt    <= 8'd0;
                            if (p_error) err_flag <= 1'b1;
                        end else if (gap_expire) begin
                            timeout <= 1'b1;
                            busy    <= 1'b0;
                            gap_cnt <= 8'd0;
                        end else begin
                            gap_cnt <= gap_cnt + 8'd1;
                        end
                    end
                    PAUSE_WAIT: begin
                        if (gap_cnt != PAUSE_CYCLES) gap_cnt <= gap_cnt + 8'd1;
                    end
                    LOAD_SW: begin
                        tx_cd   <= 1'b0;
                        tx_data <= {ADDRESS, err_flag, 10'd0};
                        rdy_cnt <= 2'd0;
                    end
                    SEND_SW: begin
                        // The request starts only while the encoder is idle.
                        // Once started it runs its two cycles.
                        case (rdy_cnt)
                            2'd0: if (!tx_busy) begin
                                tx_ready <= 1'b1;
                                rdy_cnt  <= 2'd1;
                            end
                            2'd1:    rdy_cnt  <= 2'd2;
                            default: tx_ready <= 1'b0;
                        endcase
                    end
                    END_WAIT: begin
                        if (!tx_busy) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_device_rx.sv
// ---------------------------------------------------------------------------
// tb_device_rx
//
// Directed bench for device_rx with the default parameters:
// ADDRESS=1, PAUSE_CYCLES=255, DW_TIMEOUT=200.
//
// A table of complete messages is applied in a loop. Each record holds the
// command word, the word count, the parity-error position and the word
// spacing, together with the expected status word and word count. Timeout,
// handshake, restart and reset cases are written out by hand afterwards.
//
// Inputs change 1 time unit after a rising edge. A negedge monitor logs
// memory writes and output pulses together with their cycle numbers.
// ---------------------------------------------------------------------------
module tb_device_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] rx_data = 16'd0;
    logic        rx_valid = 1'b0;
    logic        p_error = 1'b0;
    logic        tx_busy = 1'b0;
    logic [15:0] tx_data;
    logic        tx_cd;
    logic        tx_ready;
    logic [4:0]  mem_addr;
    logic [15:0] mem_data;
    logic        mem_we;
    logic        busy;
    logic [5:0]  words_rcvd;
    logic        done;
    logic        timeout;

    device_rx #(
        .ADDRESS(5'd1),
        .PAUSE_CYCLES(8'hFF),
        .DW_TIMEOUT(8'd200)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .rx_data(rx_data),
        .rx_valid(rx_valid), .p_error(p_error), .tx_data(tx_data),
        .tx_cd(tx_cd), .tx_ready(tx_ready), .tx_busy(tx_busy),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .busy(busy), .words_rcvd(words_rcvd), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Negedge monitor: write log and pulse bookkeeping.
    logic [4:0]  wr_addr [256];
    logic [15:0] wr_data [256];
    int          wr_cyc  [256];
    int          wr_n = 0;
    int          rdy_n = 0, rdy_rise_cyc = -1;
    logic        rdy_prev = 1'b0;
    int          done_n = 0, done_cyc = -1;
    int          to_n = 0, to_cyc = -1;

    always @(negedge clk) begin
        if (mem_we === 1'b1 && wr_n < 256) begin
            wr_addr[wr_n] = mem_addr;
            wr_data[wr_n] = mem_data;
            wr_cyc[wr_n]  = cyc;
            wr_n = wr_n + 1;
        end
        if (tx_ready === 1'b1) begin
            rdy_n = rdy_n + 1;
            if (rdy_prev !== 1'b1) rdy_rise_cyc = cyc;
        end
        rdy_prev = tx_ready;
        if (done === 1'b1) begin
            done_n = done_n + 1;
            done_cyc = cyc;
        end
        if (timeout === 1'b1) begin
            to_n = to_n + 1;
            to_cyc = cyc;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] cmd, input logic pe);
        start = 1'b1; rx_data = cmd; p_error = pe;
        tick();
        start = 1'b0; rx_data = 16'd0; p_error = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] d, input logic pe, input int gap);
        repeat (gap) tick();
        rx_valid = 1'b1; rx_data = d; p_error = pe;
        tick();
        rx_valid = 1'b0; rx_data = 16'd0; p_error = 1'b0;
    endtask

    task automatic wait_done(input int base, input int limit, output bit ok);
        int n;
        n = 0;
        while (done_n == base && n < limit) begin
            tick();
            n++;
        end
        ok = (done_n != base);
    endtask

    function automatic logic [15:0] word_val(input int m, input int i);
        logic [7:0] mm, ii;
        mm = 8'(m);
        ii = 8'(i);
        if (m == 0) begin
            case (i)
                0:       return 16'hA5A5;
                1:       return 16'h1234;
                default: return 16'hFFFF;
            endcase
        end
        return {mm[3:0], 4'h6, ii};
    endfunction

    typedef struct {
        logic [15:0] cmd;
        logic        cmd_perr;
        int          nwords;
        int          perr_idx;
        int          spacing;
        logic [15:0] exp_sw;
        logic [5:0]  exp_cnt;
    } msg_t;

    msg_t msgs [6];

    initial begin
        int  wb, rb, db, tb0, last_we, rel, n;
        bit  ok;

        msgs[0] = '{16'h0003, 1'b0, 3,  -1, 40,  16'h0800, 6'd3};   // normal message
        msgs[1] = '{16'hFFE0, 1'b0, 32, -1, 3,   16'h0800, 6'd32};  // count field 0 -> 32
        msgs[2] = '{16'h0004, 1'b0, 4,  1,  10,  16'h0C00, 6'd4};   // parity error on word 2
        msgs[3] = '{16'h0001, 1'b1, 1,  -1, 7,   16'h0C00, 6'd1};   // parity error on command
        msgs[4] = '{16'h0001, 1'b0, 1,  -1, 5,   16'h0800, 6'd1};   // error flag cleared again
        msgs[5] = '{16'h0002, 1'b0, 2,  -1, 199, 16'h0800, 6'd2};   // longest accepted gap

        // Reset state
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_words", words_rcvd, 0);
        check("rst_tx", {tx_data, tx_cd, tx_ready}, 0);
        check("rst_mem", {mem_addr, mem_data, mem_we}, 0);
        check("rst_pulses", {done, timeout}, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Table-driven complete messages
        for (int m = 0; m < 6; m++) begin
            wb = wr_n; rb = rdy_n; db = done_n;
            do_start(msgs[m].cmd, msgs[m].cmd_perr);
            check("busy_after_start", busy, 1);
            for (int i = 0; i < msgs[m].nwords; i++)
                send_word(word_val(m, i), (i == msgs[m].perr_idx), msgs[m].spacing);
            tick();
            check("no_ready_before_pause", rdy_n - rb, 0);
            wait_done(db, 1000, ok);
            check("done_seen", ok, 1);
            check("write_count", wr_n - wb, msgs[m].nwords);
            for (int i = 0; i < msgs[m].nwords; i++) begin
                if (wb + i < 256) begin
                    check("write_addr", wr_addr[wb + i], i);
                    check("write_data", wr_data[wb + i], word_val(m, i));
                end
            end
            check("status_word", tx_data, msgs[m].exp_sw);
            check("status_cd", tx_cd, 0);
            check("ready_cycles", rdy_n - rb, 2);
            last_we = (wr_n > 0) ? wr_cyc[wr_n - 1] : 0;
            check("ready_delay", rdy_rise_cyc - last_we, 258);
            check("done_delay", done_cyc - last_we, 261);
            check("done_count", done_n - db, 1);
            check("words_rcvd", words_rcvd, msgs[m].exp_cnt);
            check("busy_end", busy, 0);
            repeat (3) tick();
        end

        // Timeout after one word of four, then idle rx_valid ignored
        wb = wr_n; rb = rdy_n; db = done_n; tb0 = to_n;
        do_start(16'h0004, 1'b0);
        send_word(16'hBEEF, 1'b0, 5);
        n = 0;
        while (to_n == tb0 && n < 400) begin
            tick();
            n++;
        end
        check("timeout_seen", to_n - tb0, 1);
        check("timeout_delay", to_cyc - ((wr_n > 0) ? wr_cyc[wr_n - 1] : 0), 200);
        check("timeout_data", wr_data[wb], 16'hBEEF);
        check("timeout_words", words_rcvd, 1);
        check("timeout_busy", busy, 0);
        tick();
        check("timeout_pulse", timeout, 0);
        send_word(16'h7777, 1'b0, 2);
        tick();
        check("idle_ignores_word", wr_n - wb, 1);
        check("idle_words_hold", words_rcvd, 1);
        repeat (300) tick();
        check("timeout_no_ready", rdy_n - rb, 0);
        check("timeout_no_done", done_n - db, 0);

        // Handshake: encoder busy through SEND_SW and END_WAIT
        rb = rdy_n; db = done_n;
        tx_busy = 1'b1;
        do_start(16'h0001, 1'b0);
        send_word(16'h4242, 1'b0, 4);
        repeat (300) tick();
        check("hs_ready_held", rdy_n - rb, 0);
        check("hs_status_loaded", tx_data, 16'h0800);
        check("hs_busy", busy, 1);
        rel = cyc;
        tx_busy = 1'b0;
        tick();
        check("hs_ready_up", tx_ready, 1);
        tx_busy = 1'b1;
        tick();
        check("hs_ready_delay", rdy_rise_cyc - rel, 1);
        repeat (30) tick();
        check("hs_ready_cycles", rdy_n - rb, 2);
        check("hs_done_held", done_n - db, 0);
        check("hs_busy_held", busy, 1);
        rel = cyc;
        tx_busy = 1'b0;
        wait_done(db, 20, ok);
        check("hs_done_seen", ok, 1);
        check("hs_done_delay", done_cyc - rel, 1);

        // Restart during WAIT_DW
        wb = wr_n; db = done_n;
        do_start(16'h0005, 1'b0);
        send_word(16'h1111, 1'b0, 5);
        send_word(16'h2222, 1'b0, 5);
        do_start(16'h0002, 1'b0);
        send_word(16'h3333, 1'b0, 5);
        send_word(16'h4444, 1'b0, 5);
        wait_done(db, 1000, ok);
        check("rs_done_seen", ok, 1);
        check("rs_write_count", wr_n - wb, 4);
        check("rs_addr0", wr_addr[wb + 2], 0);
        check("rs_addr1", wr_addr[wb + 3], 1);
        check("rs_data", {wr_data[wb + 2], wr_data[wb + 3]}, 32'h3333_4444);
        check("rs_words", words_rcvd, 2);

        // Asynchronous reset during PAUSE_WAIT
        rb = rdy_n; db = done_n;
        do_start(16'h0001, 1'b0);
        send_word(16'h5555, 1'b0, 3);
        repeat (50) tick();
        check("pr_busy_before", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_busy", busy, 0);
        check("ar_words", words_rcvd, 0);
        check("ar_tx", {tx_data, tx_cd, tx_ready}, 0);
        check("ar_mem", {mem_addr, mem_data, mem_we}, 0);
        check("ar_pulses", {done, timeout}, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (400) tick();
        check("ar_no_ready", rdy_n - rb, 0);
        check("ar_no_done", done_n - db, 0);
        check("ar_idle_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
